// File: rtl/x_200_mod_47_loader.sv
// Assembles a 200-bit operand from WORD_W-bit words, least-significant word first,
// and holds it for the mod-47 reducer until the consumer takes it.
module x_200_mod_47_loader #(
  parameter int WORD_W  = 25,
  parameter int N_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WORD_W:1]           in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [WORD_W*N_WORDS:1]   X,
  output logic                      x_valid,
  input  logic                      x_ready,
  output logic [4:1]                x_len
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  localparam logic [4:1] LAST_IDX = 4'(N_WORDS - 1);

  state_t state, state_nxt;
  logic   word_xfer;
  logic   op_xfer;
  logic   last_word;

  assign word_xfer = in_valid && in_ready;
  assign op_xfer   = x_valid && x_ready;
  // A word completes the operand when flagged last or when it fills the final slot.
  assign last_word = in_last || (x_len == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    x_valid   = 1'b0;
    case (state)
      IDLE, FILL: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = last_word ? HOLD : FILL;
      end
      HOLD: begin
        x_valid = 1'b1;
        if (x_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // x_len doubles as the word counter, so it also selects the slot for the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X     <= '0;
      x_len <= '0;
    end else if (op_xfer) begin
      X     <= '0;
      x_len <= '0;
    end else if (word_xfer) begin
      for (int k = 0; k < N_WORDS; k++) begin
        if (x_len == k[3:0]) X[k*WORD_W+1 +: WORD_W] <= in_data;
      end
      x_len <= x_len + 4'd1;
    end
  end

endmodule

// File: tb/tb_x_200_mod_47_loader.sv
// Self-checking bench for x_200_mod_47_loader: vector table, corner sequences,
// and randomized traffic against a queue-based operand model.
module tb_x_200_mod_47_loader;

  localparam int WORD_W  = 25;
  localparam int N_WORDS = 8;
  localparam int XW      = WORD_W * N_WORDS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WORD_W:1]   in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [XW:1]       X;
  logic              x_valid;
  logic              x_ready;
  logic [4:1]        x_len;

  int total = 0;
  int bad   = 0;

  // Reference model: the accepted words of the current operand and a "complete" flag.
  logic [WORD_W:1] mq[$];
  bit              m_full;

  typedef struct {
    int                     n;
    logic [N_WORDS*WORD_W-1:0] words;
    int                     last_at;
    logic [XW:1]            exp_x;
    int                     exp_len;
    int                     exp_r;
  } vec_t;

  vec_t tbl[4];

  x_200_mod_47_loader #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .X        (X),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .x_len    (x_len)
  );

  always #5 clk = ~clk;

  function automatic int mod47(input logic [XW:1] v);
    int r = 0;
    for (int i = XW; i >= 1; i--) r = (r * 2 + int'(v[i])) % 47;
    return r;
  endfunction

  function automatic logic [XW:1] model_x();
    logic [XW:1] r = '0;
    foreach (mq[k]) r = r | (XW'(mq[k]) << (k * WORD_W));
    return r;
  endfunction

  task automatic check_output(input string name, input logic [XW:1] act, input logic [XW:1] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic v, input logic [WORD_W:1] d, input logic l, input logic xr);
    if (!m_full) begin
      if (v) begin
        mq.push_back(d);
        if (l || mq.size() == N_WORDS) m_full = 1'b1;
      end
    end else if (xr) begin
      mq.delete();
      m_full = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then settle just after the edge.
  task automatic apply_stimulus(input logic v, input logic [WORD_W:1] d, input logic l, input logic xr);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    x_ready  = xr;
    model_step(v, d, l, xr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_xvalid"}, XW'(x_valid), XW'(1'b0));
    check_output({tag, "_inready"}, XW'(in_ready), XW'(1'b1));
    check_output({tag, "_x"}, X, '0);
    check_output({tag, "_len"}, XW'(x_len), '0);
  endtask

  task automatic check_model();
    check_output("rnd_x", X, model_x());
    check_output("rnd_len", XW'(x_len), XW'(mq.size()));
    check_output("rnd_xvalid", XW'(x_valid), XW'(m_full));
    check_output("rnd_inready", XW'(in_ready), XW'(!m_full));
  endtask

  initial begin
    tbl[0] = '{8, {8{25'h1FFFFFF}}, -1, {XW{1'b1}}, 8, 17};
    tbl[1] = '{1, 200'd100, 0, 200'd100, 1, 6};
    tbl[2] = '{2, {25'd1, 25'd1}, 1, (200'd1 << 25) | 200'd1, 2, 5};
    tbl[3] = '{3, {25'd7, 25'd5, 25'd3}, 2, {25'd7, 25'd5, 25'd3}, 3, 41};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    x_ready  = 1'b0;
    mq.delete();
    m_full = 1'b0;
    #1;
    check_idle("reset");
    #7;
    rst_n = 1'b1;

    // Table-driven single operands.
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        apply_stimulus(1'b1, tbl[i].words[k*WORD_W +: WORD_W], k == tbl[i].last_at, 1'b0);
        check_output("vec_len_step", XW'(x_len), XW'(k + 1));
        if (k < tbl[i].n - 1) check_output("vec_early_xvalid", XW'(x_valid), XW'(1'b0));
      end
      check_output("vec_xvalid", XW'(x_valid), XW'(1'b1));
      check_output("vec_inready", XW'(in_ready), XW'(1'b0));
      check_output("vec_x", X, tbl[i].exp_x);
      check_output("vec_len", XW'(x_len), XW'(tbl[i].exp_len));
      check_output("vec_r", XW'(mod47(X)), XW'(tbl[i].exp_r));
      apply_stimulus(1'b0, '0, 1'b0, 1'b1);
      check_idle("vec_after");
    end

    // Single word with x_ready already high: x_valid lasts exactly one cycle.
    apply_stimulus(1'b1, 25'd100, 1'b1, 1'b1);
    check_output("one_xvalid", XW'(x_valid), XW'(1'b1));
    check_output("one_x", X, 200'd100);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("one_xvalid_drop", XW'(x_valid), XW'(1'b0));

    // Full operand stalled by x_ready=0; in_valid traffic must be ignored while held.
    for (int k = 0; k < N_WORDS; k++) apply_stimulus(1'b1, WORD_W'(3 * (k + 1)), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(1'b1, WORD_W'($urandom), 1'($urandom), 1'b0);
      check_output("stall_x", X, model_x());
      check_output("stall_len", XW'(x_len), XW'(8));
      check_output("stall_inready", XW'(in_ready), XW'(1'b0));
      check_output("stall_xvalid", XW'(x_valid), XW'(1'b1));
    end
    apply_stimulus(1'b1, 25'h55, 1'b1, 1'b1);
    check_idle("stall_release");
    apply_stimulus(1'b1, 25'h1234, 1'b1, 1'b0);
    check_output("stall_next_x", X, 200'h1234);
    check_output("stall_next_len", XW'(x_len), XW'(1));
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a partial operand.
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, WORD_W'(k + 11), 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    mq.delete();
    m_full = 1'b0;
    #3;
    rst_n = 1'b1;
    apply_stimulus(1'b1, 25'd7, 1'b1, 1'b0);
    check_output("post_rst_x", X, 200'd7);
    check_output("post_rst_len", XW'(x_len), XW'(1));
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus(1'($urandom % 4 != 0), WORD_W'($urandom), 1'($urandom % 5 == 0),
                     1'($urandom % 3 == 0));
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
